// File: rtl/memory_stage_hs.sv
`timescale 1ns/1ps
// MEM stage: drives a ready/valid data-memory port, stalls the pipeline while an
// access is outstanding, aligns/extends loads and retires faults into MEM/WB.
module memory_stage_hs #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_DMEM_ADDR_WIDTH = 11,
  parameter int P_PC_WIDTH        = 11,
  parameter int P_TIMEOUT         = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid_m,
  input  logic                         i_regwrite_m,
  input  logic [1:0]                   i_resultsrc_m,
  input  logic                         i_memread_m,
  input  logic                         i_memwrite_m,
  input  logic [2:0]                   i_funct3_m,
  input  logic [P_DATA_WIDTH-1:0]      i_alu_result_m,
  input  logic [P_DATA_WIDTH-1:0]      i_write_data_m,
  input  logic [4:0]                   i_rd_addr_m,
  input  logic [P_PC_WIDTH-1:0]        i_pc4_m,
  output logic                         o_stall_m,
  output logic                         o_dmem_req,
  output logic                         o_dmem_we,
  output logic [P_DMEM_ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [3:0]                   o_dmem_be,
  output logic [P_DATA_WIDTH-1:0]      o_dmem_wdata,
  input  logic                         i_dmem_ready,
  input  logic                         i_dmem_rvalid,
  input  logic [P_DATA_WIDTH-1:0]      i_dmem_rdata,
  output logic                         o_valid_w,
  output logic                         o_regwrite_w,
  output logic [1:0]                   o_resultsrc_w,
  output logic [4:0]                   o_rd_addr_w,
  output logic [P_PC_WIDTH-1:0]        o_pc4_w,
  output logic [P_DATA_WIDTH-1:0]      o_alu_result_w,
  output logic [P_DATA_WIDTH-1:0]      o_read_data_w,
  output logic [1:0]                   o_fault_w,
  output logic [1:0]                   o_dbg_state
);

  localparam int CW = $clog2(P_TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(P_TIMEOUT - 1);
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

  logic [1:0]              state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic                    mem_op, illegal, misaligned, req, stall;
  logic [1:0]              lane, chk_fault, ret_fault;
  logic [3:0]              st_be;
  logic [P_DATA_WIDTH-1:0] st_wdata, ld_ext, ret_rdata;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;

  assign mem_op = i_valid_m & (i_memread_m | i_memwrite_m);
  assign lane   = i_alu_result_m[1:0];

  assign illegal    = (i_funct3_m == 3'b011) | (i_funct3_m[2:1] == 2'b11) |
                      (i_memwrite_m & i_funct3_m[2]);
  assign misaligned = ((i_funct3_m[1:0] == 2'b01) & lane[0]) |
                      ((i_funct3_m[1:0] == 2'b10) & (lane != 2'b00));
  assign chk_fault  = illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);

  // Store lane placement; a write wins over a read when both are requested.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = i_write_data_m;
    case (i_funct3_m[1:0])
      2'b00: begin
        st_be    = 4'b0001 << lane;
        st_wdata = {4{i_write_data_m[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << lane;
        st_wdata = {2{i_write_data_m[15:0]}};
      end
      default: ;
    endcase
    if (!i_memwrite_m) st_be = 4'b0000;
  end

  always_comb begin
    ld_byte = i_dmem_rdata[7:0];
    case (lane)
      2'b01:   ld_byte = i_dmem_rdata[15:8];
      2'b10:   ld_byte = i_dmem_rdata[23:16];
      2'b11:   ld_byte = i_dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = lane[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (i_funct3_m)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = i_dmem_rdata;
    endcase
  end

  // The counter starts at 1 on leaving a phase's first cycle, so a phase lasts at
  // most P_TIMEOUT cycles including the cycle that began it.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req       = 1'b0;
    stall     = 1'b0;
    ret_fault = 2'b00;
    ret_rdata = '0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (mem_op) begin
          if (chk_fault != 2'b00) begin
            ret_fault = chk_fault;
          end else begin
            req = 1'b1;
            if (!i_dmem_ready) begin
              stall    = 1'b1;
              state_nx = S_REQ;
              cnt_nx   = CW'(1);
            end else if (!i_memwrite_m) begin
              stall    = 1'b1;
              state_nx = S_RESP;
              cnt_nx   = CW'(1);
            end
          end
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (i_dmem_ready) begin
          if (i_memwrite_m) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else begin
            stall    = 1'b1;
            state_nx = S_RESP;
            cnt_nx   = CW'(1);
          end
        end else if (cnt == TO_LAST) begin
          ret_fault = 2'b10;
          state_nx  = S_IDLE;
          cnt_nx    = '0;
        end else begin
          stall  = 1'b1;
          cnt_nx = cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (i_dmem_rvalid) begin
          ret_rdata = ld_ext;
          state_nx  = S_IDLE;
          cnt_nx    = '0;
        end else if (cnt == TO_LAST) begin
          ret_fault = 2'b10;
          state_nx  = S_IDLE;
          cnt_nx    = '0;
        end else begin
          stall  = 1'b1;
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Memory-side outputs are forced low while reset is asserted.
  assign o_stall_m    = stall & i_rst_n;
  assign o_dmem_req   = req & i_rst_n;
  assign o_dmem_we    = i_valid_m & i_memwrite_m & i_rst_n;
  assign o_dmem_addr  = i_rst_n ? i_alu_result_m[P_DMEM_ADDR_WIDTH-1:0] : '0;
  assign o_dmem_be    = i_rst_n ? st_be : 4'b0000;
  assign o_dmem_wdata = i_rst_n ? st_wdata : '0;
  assign o_dbg_state  = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      o_valid_w      <= 1'b0;
      o_regwrite_w   <= 1'b0;
      o_resultsrc_w  <= 2'b00;
      o_rd_addr_w    <= 5'd0;
      o_pc4_w        <= '0;
      o_alu_result_w <= '0;
      o_read_data_w  <= '0;
      o_fault_w      <= 2'b00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (stall) begin
        o_valid_w      <= 1'b0;
        o_regwrite_w   <= 1'b0;
        o_resultsrc_w  <= 2'b00;
        o_rd_addr_w    <= 5'd0;
        o_pc4_w        <= '0;
        o_alu_result_w <= '0;
        o_read_data_w  <= '0;
        o_fault_w      <= 2'b00;
      end else begin
        o_valid_w      <= i_valid_m;
        o_regwrite_w   <= i_valid_m & i_regwrite_m & (ret_fault == 2'b00);
        o_resultsrc_w  <= i_resultsrc_m;
        o_rd_addr_w    <= i_rd_addr_m;
        o_pc4_w        <= i_pc4_m;
        o_alu_result_w <= i_alu_result_m;
        o_read_data_w  <= ret_rdata;
        o_fault_w      <= ret_fault;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage_hs.sv
`timescale 1ns/1ps
// Bench for memory_stage_hs: random ops with a transaction-level phase model,
// a per-cycle compare process and a few literal expectations.
module tb_memory_stage_hs;

  localparam int TO = 16;
  localparam int EW = 86;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid_m, i_regwrite_m, i_memread_m, i_memwrite_m;
  logic [1:0]  i_resultsrc_m;
  logic [2:0]  i_funct3_m;
  logic [31:0] i_alu_result_m, i_write_data_m, i_dmem_rdata;
  logic [4:0]  i_rd_addr_m;
  logic [10:0] i_pc4_m;
  logic        i_dmem_ready, i_dmem_rvalid;
  logic        o_stall_m, o_dmem_req, o_dmem_we;
  logic [10:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        o_valid_w, o_regwrite_w;
  logic [1:0]  o_resultsrc_w, o_fault_w, o_dbg_state;
  logic [4:0]  o_rd_addr_w;
  logic [10:0] o_pc4_w;
  logic [31:0] o_alu_result_w, o_read_data_w;

  memory_stage_hs #(.P_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid_m(i_valid_m), .i_regwrite_m(i_regwrite_m),
    .i_resultsrc_m(i_resultsrc_m), .i_memread_m(i_memread_m), .i_memwrite_m(i_memwrite_m),
    .i_funct3_m(i_funct3_m), .i_alu_result_m(i_alu_result_m), .i_write_data_m(i_write_data_m),
    .i_rd_addr_m(i_rd_addr_m), .i_pc4_m(i_pc4_m), .o_stall_m(o_stall_m), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid),
    .i_dmem_rdata(i_dmem_rdata), .o_valid_w(o_valid_w), .o_regwrite_w(o_regwrite_w),
    .o_resultsrc_w(o_resultsrc_w), .o_rd_addr_w(o_rd_addr_w), .o_pc4_w(o_pc4_w),
    .o_alu_result_w(o_alu_result_w), .o_read_data_w(o_read_data_w), .o_fault_w(o_fault_w),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        valid, regwrite, rd_en, wr_en;
    logic [1:0]  rsrc;
    logic [2:0]  f3;
    logic [31:0] alu, wd, rdata;
    logic [4:0]  rd;
    logic [10:0] pc4;
    int          d, r;   // cycle index where ready appears; cycles from accept to rvalid
  } op_t;

  int checks = 0, failures = 0;
  logic [EW-1:0] exp_q[$];
  bit          chk_en = 1'b0, cur_retire = 1'b0, last_retire = 1'b0;
  bit          exp_stall, exp_req, exp_we, exp_chk_wd;
  logic [3:0]  exp_be;
  logic [10:0] exp_addr;
  logic [31:0] exp_wdata;
  int          req_seen, stall_seen;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [1:0] model_fault(input op_t op);
    bit illegal, mis;
    illegal = (op.f3 == 3) || (op.f3 == 6) || (op.f3 == 7) ||
              (op.wr_en && (op.f3 == 4 || op.f3 == 5));
    mis = (int'(op.alu[1:0]) % nbytes(op.f3)) != 0;
    return illegal ? 2'b11 : (mis ? 2'b01 : 2'b00);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rdata);
    int nb, first;
    logic [63:0] v;
    nb    = nbytes(f3);
    first = (int'(a) / nb) * nb;
    v = ({32'd0, rdata} >> (8 * first)) & ((64'd1 << (8 * nb)) - 64'd1);
    if (!f3[2] && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    logic [7:0] m;
    m = 8'(((1 << nbytes(f3)) - 1) << a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    int nb;
    nb = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic op_t blank();
    op_t o;
    o.valid = 0; o.regwrite = 0; o.rd_en = 0; o.wr_en = 0; o.rsrc = 0; o.f3 = 0;
    o.alu = 0; o.wd = 0; o.rdata = 0; o.rd = 0; o.pc4 = 0; o.d = 0; o.r = 1;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k;
    logic [2:0] legal [5];
    legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    o = blank();
    o.valid    = ($urandom_range(0, 9) != 0);
    o.regwrite = 1'($urandom_range(0, 1));
    o.rsrc     = 2'($urandom_range(0, 3));
    k = $urandom_range(0, 3);
    o.rd_en = (k == 1 || k == 3);
    o.wr_en = (k == 2 || k == 3);
    o.f3    = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
    o.alu   = $urandom();
    if ($urandom_range(0, 1) == 1) o.alu[1:0] = 2'b00;
    o.wd    = $urandom();
    o.rdata = $urandom();
    o.rd    = 5'($urandom_range(0, 31));
    o.pc4   = 11'($urandom_range(0, 2047));
    o.d     = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 3);
    o.r     = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(1, 3);
    return o;
  endfunction

  // Driver: plans the op's phases, then presents it held for every cycle it occupies.
  task automatic run_op(input op_t op);
    bit mem, got;
    logic [1:0] f;
    logic [31:0] rd_exp;
    int n, req_cyc, acc;
    mem = op.valid && (op.rd_en || op.wr_en);
    f   = mem ? model_fault(op) : 2'b00;
    n = 1; req_cyc = 0; acc = -1; got = 0; rd_exp = 0;
    if (mem && f == 2'b00) begin
      if (op.d > TO - 1) begin
        n = TO; req_cyc = TO; f = 2'b10;
      end else if (op.wr_en) begin
        n = op.d + 1; req_cyc = n;
      end else begin
        acc = op.d; req_cyc = op.d + 1;
        if (op.r <= TO - 1) begin
          n = acc + op.r + 1; got = 1; rd_exp = model_load(op.f3, op.alu[1:0], op.rdata);
        end else begin
          n = acc + TO; f = 2'b10;
        end
      end
    end
    req_seen = 0; stall_seen = 0;
    for (int idx = 0; idx < n; idx++) begin
      i_valid_m = op.valid; i_regwrite_m = op.regwrite; i_resultsrc_m = op.rsrc;
      i_memread_m = op.rd_en; i_memwrite_m = op.wr_en; i_funct3_m = op.f3;
      i_alu_result_m = op.alu; i_write_data_m = op.wd; i_rd_addr_m = op.rd; i_pc4_m = op.pc4;
      i_dmem_ready  = (idx < req_cyc) ? (idx == op.d) : 1'($urandom_range(0, 1));
      i_dmem_rvalid = (acc >= 0 && idx > acc) ? (idx == acc + op.r) : 1'($urandom_range(0, 1));
      i_dmem_rdata  = (acc >= 0 && idx == acc + op.r) ? op.rdata : $urandom();
      exp_stall  = (idx < n - 1);
      exp_req    = (idx < req_cyc);
      exp_we     = op.wr_en;
      exp_be     = op.wr_en ? model_be(op.f3, op.alu[1:0]) : 4'b0000;
      exp_addr   = op.alu[10:0];
      exp_wdata  = model_wdata(op.f3, op.wd);
      exp_chk_wd = op.wr_en;
      cur_retire = op.valid && (idx == n - 1);
      if (cur_retire)
        exp_q.push_back({op.regwrite && (f == 2'b00), op.rsrc, op.rd, op.pc4, op.alu, f, got, rd_exp});
      #1;
      if (o_dmem_req) begin
        req_seen++; seen_be = o_dmem_be; seen_wdata = o_dmem_wdata;
      end
      if (o_stall_m) stall_seen++;
      @(posedge i_clk); #2;
    end
  endtask

  // Scoreboard / compare process
  always @(negedge i_clk) begin : cmp
    logic [EW-1:0] e;
    if (!chk_en) begin
      last_retire = 1'b0;
    end else begin
      chk("valid_w", o_valid_w, last_retire);
      if (last_retire) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_empty actual=retire required=expectation t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("regwrite_w", o_regwrite_w, e[85]);
          chk("resultsrc_w", o_resultsrc_w, e[84:83]);
          chk("rd_addr_w", o_rd_addr_w, e[82:78]);
          chk("pc4_w", o_pc4_w, e[77:67]);
          chk("alu_result_w", o_alu_result_w, e[66:35]);
          chk("fault_w", o_fault_w, e[34:33]);
          if (e[32]) chk("read_data_w", o_read_data_w, e[31:0]);
        end
      end else begin
        chk("bubble_regwrite", o_regwrite_w, 0);
      end
      chk("stall_m", o_stall_m, exp_stall);
      chk("dmem_req", o_dmem_req, exp_req);
      if (exp_req) begin
        chk("dmem_we", o_dmem_we, exp_we);
        chk("dmem_be", o_dmem_be, exp_be);
        chk("dmem_addr", o_dmem_addr, exp_addr);
        if (exp_chk_wd) chk("dmem_wdata", o_dmem_wdata, exp_wdata);
      end
      last_retire = cur_retire;
    end
  end

  initial begin : main
    op_t op;
    i_rst_n = 1'b1;
    i_valid_m = 0; i_regwrite_m = 0; i_resultsrc_m = 0; i_memread_m = 0; i_memwrite_m = 0;
    i_funct3_m = 0; i_alu_result_m = 0; i_write_data_m = 0; i_rd_addr_m = 0; i_pc4_m = 0;
    i_dmem_ready = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
    #1 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #2;
    chk("reset_valid_w", o_valid_w, 0);
    chk("reset_dmem_req", o_dmem_req, 0);
    chk("reset_stall", o_stall_m, 0);
    chk("reset_read_data", o_read_data_w, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #2;
    chk_en = 1'b1;

    // ALU op passes straight through
    op = blank(); op.valid = 1; op.regwrite = 1; op.rd = 5; op.alu = 32'h1234;
    run_op(op);
    chk("alu_valid", o_valid_w, 1);
    chk("alu_result", o_alu_result_w, 32'h1234);
    chk("alu_rd", o_rd_addr_w, 5);
    chk("alu_stall_cycles", stall_seen, 0);

    // SB to lane 3
    op = blank(); op.valid = 1; op.wr_en = 1; op.f3 = 3'b000; op.alu = 32'h3; op.wd = 32'hAB; op.d = 0;
    run_op(op);
    chk("sb_be", seen_be, 4'b1000);
    chk("sb_wdata", seen_wdata, 32'hABABABAB);
    chk("sb_req_cycles", req_seen, 1);
    chk("sb_stall_cycles", stall_seen, 0);

    // LB / LBU from lane 2, rvalid three cycles after accept
    op = blank(); op.valid = 1; op.regwrite = 1; op.rd_en = 1; op.f3 = 3'b000; op.alu = 32'h2;
    op.d = 0; op.r = 3; op.rdata = 32'h0080FF00; op.rd = 9;
    run_op(op);
    chk("lb_data", o_read_data_w, 32'hFFFFFF80);
    chk("lb_stall_cycles", stall_seen, 3);
    op.f3 = 3'b100;
    run_op(op);
    chk("lbu_data", o_read_data_w, 32'h00000080);

    // Misaligned LW and illegal SH-unsigned
    op = blank(); op.valid = 1; op.regwrite = 1; op.rd_en = 1; op.f3 = 3'b010; op.alu = 32'h6;
    run_op(op);
    chk("lw_mis_fault", o_fault_w, 2'b01);
    chk("lw_mis_regwrite", o_regwrite_w, 0);
    chk("lw_mis_req_cycles", req_seen, 0);
    op = blank(); op.valid = 1; op.wr_en = 1; op.f3 = 3'b101; op.alu = 32'h4;
    run_op(op);
    chk("sh_illegal_fault", o_fault_w, 2'b11);

    // SW that never sees ready
    op = blank(); op.valid = 1; op.regwrite = 1; op.wr_en = 1; op.f3 = 3'b010; op.alu = 32'h8;
    op.d = 20;
    run_op(op);
    chk("sw_timeout_req_cycles", req_seen, TO);
    chk("sw_timeout_fault", o_fault_w, 2'b10);
    chk("sw_timeout_regwrite", o_regwrite_w, 0);
    run_op(blank());

    // Reset during RESP abandons the load; a later rvalid is ignored
    chk_en = 1'b0;
    i_valid_m = 1; i_regwrite_m = 1; i_memread_m = 1; i_memwrite_m = 0; i_funct3_m = 3'b010;
    i_alu_result_m = 32'h10; i_rd_addr_m = 7; i_dmem_ready = 1; i_dmem_rvalid = 0;
    @(posedge i_clk); #2;
    i_dmem_ready = 0;
    repeat (2) begin @(posedge i_clk); #2; end
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_req", o_dmem_req, 0);
    chk("rst_mid_stall", o_stall_m, 0);
    chk("rst_mid_valid_w", o_valid_w, 0);
    chk("rst_mid_fault", o_fault_w, 0);
    i_valid_m = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'hDEADBEEF;
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #2;
      chk("stale_rvalid_valid_w", o_valid_w, 0);
      chk("stale_rvalid_stall", o_stall_m, 0);
    end
    i_dmem_rvalid = 0;
    chk_en = 1'b1;
    run_op(blank());

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      run_op(rand_op());
      if ($urandom_range(0, 3) == 0) run_op(blank());
    end
    run_op(blank());
    run_op(blank());
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
